altsyncram_lane_shadow_model: RTL

//  Parametrised validity-shadow model of a simple dual-port altsyncram: write-only port A, read-only

---
 rtl/altsyncram_lane_shadow_model.sv | 117 +++++++++++
 1 files changed

// File: rtl/altsyncram_lane_shadow_model.sv
// Per-lane validity shadow of a simple dual-port RAM; valid_b follows address_b by rd_latency edges.
// No backpressure: rden_b low freezes the whole read pipeline, writes are never stalled.
module altsyncram_lane_shadow_model #(
    parameter int numwords   = 256,
    parameter int widthad    = 8,
    parameter int lanes      = 4,
    parameter int rd_latency = 2,
    parameter int rdw_mode   = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wren_a,
    input  logic [widthad-1:0] address_a,
    input  logic [lanes-1:0]   byteena_a,
    input  logic [lanes-1:0]   valid_a,
    input  logic               rden_b,
    input  logic [widthad-1:0] address_b,
    output logic [lanes-1:0]   valid_b,
    output logic               av_b,
    output logic               ai_b,
    output logic               assign_b,
    output logic [lanes-1:0]   valid_q_b,
    output logic               av_q_b,
    output logic               ai_q_b,
    output logic               assign_q_b
);

    localparam logic [widthad:0] NUM_WORDS = (widthad + 1)'(numwords);

    generate
        if (rd_latency != 1 && rd_latency != 2) begin : g_bad_latency
            $error("rd_latency must be 1 or 2");
        end
        if (rdw_mode < 0 || rdw_mode > 2) begin : g_bad_rdw
            $error("rdw_mode must be 0, 1 or 2");
        end
        if (numwords < 1 || numwords > (1 << widthad)) begin : g_bad_depth
            $error("numwords must be in 1..2**widthad");
        end
    endgenerate

    logic [lanes-1:0] valid_ram [numwords];
    logic [lanes-1:0] rd_raw;
    logic [lanes-1:0] rd_next;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_hit;

    assign wr_in_range = {1'b0, address_a} < NUM_WORDS;
    assign rd_in_range = {1'b0, address_b} < NUM_WORDS;
    assign wr_hit      = wren_a && wr_in_range && (address_a == address_b);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < numwords; i++) begin
                valid_ram[i] <= '0;
            end
        end else if (wren_a && wr_in_range) begin
            valid_ram[address_a] <= (valid_ram[address_a] & ~byteena_a) | (valid_a & byteena_a);
        end
    end

    // Same-address collision resolves against the entry as it stood before this edge's write.
    always_comb begin
        rd_next = '0;
        if (rd_in_range) begin
            rd_next = valid_ram[address_b];
            if (wr_hit) begin
                case (rdw_mode)
                    1:       rd_next = (valid_ram[address_b] & ~byteena_a) | (valid_a & byteena_a);
                    2:       rd_next = '0;
                    default: rd_next = valid_ram[address_b];
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_raw <= '0;
        end else if (rden_b) begin
            rd_raw <= rd_next;
        end
    end

    generate
        if (rd_latency == 2) begin : g_lat2
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_b <= '0;
                end else if (rden_b) begin
                    valid_b <= rd_raw;
                end
            end
        end else begin : g_lat1
            assign valid_b = rd_raw;
        end
    endgenerate

    assign av_b     = &valid_b;
    assign ai_b     = ~|valid_b;
    assign assign_b = av_b | ai_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q_b <= '0;
        end else begin
            valid_q_b <= valid_b;
        end
    end

    // Flags of the delayed word equal the delayed flags, so derive them rather than store them.
    assign av_q_b     = &valid_q_b;
    assign ai_q_b     = ~|valid_q_b;
    assign assign_q_b = av_q_b | ai_q_b;

endmodule
